// File: rtl/clk_source_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_source_pkg
//  Description : Shared types for the N-way clock-source selection controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_source_pkg;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        PLL_RST   = 2'd1,
        WAIT_LOCK = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Encoding 3 is not listed; it behaves as MODE_PRIO.
    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_PRIO   = 2'd1,
        MODE_STICKY = 2'd2
    } mode_t;

endpackage
`default_nettype wire

// File: rtl/src_qualifier.sv
`default_nettype none
// ============================================================================
//  Module      : src_qualifier
//  Description : Per-source run-length qualifier of the activity flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module src_qualifier
    import clk_source_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int QUAL_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_active,
    output logic [N_SRC-1:0] src_qualified
);

    localparam int c_QUAL_W = $clog2(QUAL_CYCLES + 1);
    localparam logic [c_QUAL_W-1:0] c_LAST = c_QUAL_W'(QUAL_CYCLES - 1);

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        logic [c_QUAL_W-1:0] r_cnt;
        logic                r_qual;

        // The counter parks at c_LAST once qualified; any inactive cycle restarts it.
        always_ff @(posedge clk) begin
            if (rst || !src_active[i]) begin
                r_cnt  <= '0;
                r_qual <= 1'b0;
            end else if (r_cnt == c_LAST) begin
                r_qual <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign src_qualified[i] = r_qual;
    end

endmodule
`default_nettype wire

// File: rtl/clk_source_sel.sv
`default_nettype none
// ============================================================================
//  Module      : clk_source_sel
//  Description : N-way glitch-safe clock-source switch with MMCM lock supervision.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_source_sel
    import clk_source_pkg::*;
#(
    parameter  int N_SRC        = 4,
    parameter  int DEFAULT_SRC  = N_SRC - 1,
    parameter  int QUAL_CYCLES  = 1024,
    parameter  int DEAD_CYCLES  = 16,
    parameter  int RST_CYCLES   = 64,
    parameter  int LOCK_TIMEOUT = 65535,
    parameter  int CNT_W        = 16,
    localparam int SEL_W        = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_active,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] manual_sel,
    input  logic             mmcm_locked,
    input  logic             fail_clear,
    output logic [N_SRC-1:0] sel_onehot,
    output logic [SEL_W-1:0] sel_idx,
    output logic             mmcm_rst,
    output logic             locked_out,
    output logic [N_SRC-1:0] src_qualified,
    output logic [CNT_W-1:0] switch_count,
    output logic             lock_fail
);

    localparam int c_TMR_MAX = (LOCK_TIMEOUT > RST_CYCLES)
                             ? ((LOCK_TIMEOUT > DEAD_CYCLES) ? LOCK_TIMEOUT : DEAD_CYCLES)
                             : ((RST_CYCLES > DEAD_CYCLES) ? RST_CYCLES : DEAD_CYCLES);
    localparam int c_TMR_W = $clog2(c_TMR_MAX + 1);

    localparam logic [SEL_W-1:0]   c_DEFAULT   = SEL_W'(DEFAULT_SRC);
    localparam logic [c_TMR_W-1:0] c_DEAD_LAST = c_TMR_W'(DEAD_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_RST_LAST  = c_TMR_W'(RST_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_LOCK_LAST = c_TMR_W'(LOCK_TIMEOUT - 1);

    state_t             r_state;
    logic [c_TMR_W-1:0] r_timer;
    logic [SEL_W-1:0]   w_target;
    logic [N_SRC-1:0]   w_qual;

    src_qualifier #(
        .N_SRC       (N_SRC),
        .QUAL_CYCLES (QUAL_CYCLES)
    ) u_qual (
        .clk           (clk),
        .rst           (rst),
        .src_active    (src_active),
        .src_qualified (w_qual)
    );

    assign src_qualified = w_qual;

    function automatic logic [SEL_W-1:0] f_lowest(input logic [N_SRC-1:0] q);
        logic [SEL_W-1:0] idx;
        idx = c_DEFAULT;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (q[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [SEL_W-1:0] f_target(
        input logic [1:0]       md,
        input logic [SEL_W-1:0] req,
        input logic [N_SRC-1:0] q,
        input logic [SEL_W-1:0] cur
    );
        logic [SEL_W-1:0] want;
        logic [SEL_W-1:0] tgt;
        want = (32'(req) < N_SRC) ? req : c_DEFAULT;
        tgt  = f_lowest(q);
        if (md == MODE_MANUAL) begin
            if (q[want]) tgt = want;
        end else if (md == MODE_STICKY) begin
            if (q[cur]) tgt = cur;
        end
        return tgt;
    endfunction

    function automatic logic [N_SRC-1:0] f_onehot(input logic [SEL_W-1:0] idx);
        logic [N_SRC-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    assign w_target = f_target(mode, manual_sel, w_qual, sel_idx);

    // Every path into OFF drops the selects and re-latches the target, so the
    // BUFGCTRL never sees two selects high and the MMCM is always reset first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= OFF;
            r_timer      <= '0;
            sel_idx      <= c_DEFAULT;
            sel_onehot   <= '0;
            mmcm_rst     <= 1'b1;
            locked_out   <= 1'b0;
            switch_count <= '0;
            lock_fail    <= 1'b0;
        end else begin
            r_timer <= r_timer + 1'b1;
            if (fail_clear) lock_fail <= 1'b0;
            case (r_state)
                OFF: begin
                    if (r_timer == c_DEAD_LAST) begin
                        r_state    <= PLL_RST;
                        r_timer    <= '0;
                        sel_onehot <= f_onehot(sel_idx);
                    end
                end
                PLL_RST: begin
                    if (r_timer == c_RST_LAST) begin
                        r_state  <= WAIT_LOCK;
                        r_timer  <= '0;
                        mmcm_rst <= 1'b0;
                    end
                end
                WAIT_LOCK: begin
                    if (mmcm_locked) begin
                        r_state    <= RUN;
                        locked_out <= 1'b1;
                    end else if (r_timer == c_LOCK_LAST) begin
                        lock_fail  <= 1'b1;
                        r_state    <= OFF;
                        r_timer    <= '0;
                        sel_idx    <= w_target;
                        sel_onehot <= '0;
                        mmcm_rst   <= 1'b1;
                    end
                end
                RUN: begin
                    if ((w_target != sel_idx) || !mmcm_locked) begin
                        if ((w_target != sel_idx) && (switch_count != '1))
                            switch_count <= switch_count + 1'b1;
                        r_state    <= OFF;
                        r_timer    <= '0;
                        sel_idx    <= w_target;
                        sel_onehot <= '0;
                        mmcm_rst   <= 1'b1;
                        locked_out <= 1'b0;
                    end
                end
                default: r_state <= OFF;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_source_sel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_source_sel
//  Description : Self-checking bench with a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_source_sel;

    localparam int N     = 4;
    localparam int DEF   = 3;
    localparam int QUAL  = 64;
    localparam int DEAD  = 16;
    localparam int RSTC  = 64;
    localparam int LTO   = 200;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    localparam int M_OFF  = 0;
    localparam int M_PLL  = 1;
    localparam int M_WAIT = 2;
    localparam int M_RUN  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  src_active;
    logic [1:0]    mode;
    logic [1:0]    manual_sel;
    logic          mmcm_locked;
    logic          fail_clear;
    logic [N-1:0]  sel_onehot;
    logic [1:0]    sel_idx;
    logic          mmcm_rst;
    logic          locked_out;
    logic [N-1:0]  src_qualified;
    logic [CW-1:0] switch_count;
    logic          lock_fail;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    clk_source_sel #(
        .N_SRC(N), .DEFAULT_SRC(DEF), .QUAL_CYCLES(QUAL), .DEAD_CYCLES(DEAD),
        .RST_CYCLES(RSTC), .LOCK_TIMEOUT(LTO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .src_active(src_active), .mode(mode),
        .manual_sel(manual_sel), .mmcm_locked(mmcm_locked), .fail_clear(fail_clear),
        .sel_onehot(sel_onehot), .sel_idx(sel_idx), .mmcm_rst(mmcm_rst),
        .locked_out(locked_out), .src_qualified(src_qualified),
        .switch_count(switch_count), .lock_fail(lock_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: run lengths, remaining-cycle countdowns and a target rule.
    int           m_streak[N];
    logic [N-1:0] m_qual;
    int           m_state, m_left, m_sel, m_cnt;
    bit           m_fail;

    function automatic int exp_target(int md, int msel, logic [N-1:0] q, int cur);
        int lowest = DEF;
        int want;
        for (int i = N - 1; i >= 0; i--) if (q[i]) lowest = i;
        if (md == 0) begin
            want = (msel >= N) ? DEF : msel;
            return q[want] ? want : lowest;
        end
        if (md == 2) return q[cur] ? cur : lowest;
        return lowest;
    endfunction

    always @(posedge clk) begin
        int  tgt;
        bit  set_fail;
        bit  to_off;
        if (rst) begin
            for (int i = 0; i < N; i++) m_streak[i] = 0;
            m_qual  = '0;
            m_state = M_OFF;
            m_left  = DEAD;
            m_sel   = DEF;
            m_cnt   = 0;
            m_fail  = 1'b0;
        end else begin
            tgt      = exp_target(int'(mode), int'(manual_sel), m_qual, m_sel);
            set_fail = 1'b0;
            to_off   = 1'b0;
            case (m_state)
                M_OFF: begin
                    m_left--;
                    if (m_left == 0) begin m_state = M_PLL; m_left = RSTC; end
                end
                M_PLL: begin
                    m_left--;
                    if (m_left == 0) begin m_state = M_WAIT; m_left = LTO; end
                end
                M_WAIT: begin
                    if (mmcm_locked) m_state = M_RUN;
                    else begin
                        m_left--;
                        if (m_left == 0) begin set_fail = 1'b1; to_off = 1'b1; end
                    end
                end
                default: begin
                    if (tgt != m_sel) begin
                        if (m_cnt < CMAX) m_cnt++;
                        to_off = 1'b1;
                    end else if (!mmcm_locked) to_off = 1'b1;
                end
            endcase
            if (to_off) begin m_state = M_OFF; m_left = DEAD; m_sel = tgt; end
            if (set_fail) m_fail = 1'b1;
            else if (fail_clear) m_fail = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_streak[i] = src_active[i] ? m_streak[i] + 1 : 0;
                m_qual[i]   = (m_streak[i] >= QUAL);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("onehot", 32'(sel_onehot), (m_state == M_OFF) ? 32'd0 : (32'd1 << m_sel));
            chk("sel_idx", 32'(sel_idx), m_sel);
            chk("mmcm_rst", 32'(mmcm_rst), 32'((m_state == M_OFF) || (m_state == M_PLL)));
            chk("locked_out", 32'(locked_out), 32'(m_state == M_RUN));
            chk("qualified", 32'(src_qualified), 32'(m_qual));
            chk("switch_count", 32'(switch_count), m_cnt);
            chk("lock_fail", 32'(lock_fail), 32'(m_fail));
        end
    end

    initial begin
        rst = 1'b1; src_active = '0; mode = 2'd1; manual_sel = '0;
        mmcm_locked = 1'b0; fail_clear = 1'b0;
        step(3);
        chk_en = 1'b1;
        chk("rst_onehot", 32'(sel_onehot), 0);
        chk("rst_sel", 32'(sel_idx), 3);
        chk("rst_mmcm_rst", 32'(mmcm_rst), 1);
        chk("rst_count", 32'(switch_count), 0);

        // Start-up from reset onto the default source
        rst = 1'b0;
        step(15); chk("boot_off", 32'(sel_onehot), 0);
        step(1);  chk("boot_onehot", 32'(sel_onehot), 32'h8);
        step(63); chk("boot_rst_hold", 32'(mmcm_rst), 1);
        step(1);  chk("boot_rst_low", 32'(mmcm_rst), 0);
        step(99); chk("boot_unlocked", 32'(locked_out), 0);
        mmcm_locked = 1'b1;
        step(1);  chk("boot_locked", 32'(locked_out), 1);

        // Auto-priority: src 1 qualifies and takes over
        src_active = 4'b0010;
        step(63); chk("prio_q_early", 32'(src_qualified), 0);
        step(1);  chk("prio_q", 32'(src_qualified), 32'h2);
        step(1);  chk("prio_sel", 32'(sel_idx), 1);
        chk("prio_cnt", 32'(switch_count), 1);
        chk("prio_off", 32'(sel_onehot), 0);
        step(81); chk("prio_run", 32'(sel_onehot), 32'h2);

        // Auto-sticky: src 0 qualifying does not steal; losing src 1 does switch
        mode = 2'd2; src_active = 4'b0011;
        step(70); chk("sticky_hold", 32'(sel_idx), 1);
        src_active = 4'b0001;
        step(1);  chk("sticky_q", 32'(src_qualified), 32'h1);
        step(1);  chk("sticky_sel", 32'(sel_idx), 0);
        chk("sticky_cnt", 32'(switch_count), 2);
        step(81); chk("sticky_run", 32'(locked_out), 1);

        // Manual: request of an unqualified source falls back, then follows
        mode = 2'd0; manual_sel = 2'd2;
        step(5);  chk("man_fallback", 32'(sel_idx), 0);
        src_active = 4'b0101;
        step(65); chk("man_sel", 32'(sel_idx), 2);
        chk("man_cnt", 32'(switch_count), 3);
        step(81); chk("man_run", 32'(sel_onehot), 32'h4);

        // Lock loss, timeout, clear and set-wins
        mmcm_locked = 1'b0;
        step(1);  chk("loss_lock", 32'(locked_out), 0);
        chk("loss_rst", 32'(mmcm_rst), 1);
        chk("loss_cnt", 32'(switch_count), 3);
        step(279); chk("to_early", 32'(lock_fail), 0);
        step(1);   chk("to_set", 32'(lock_fail), 1);
        fail_clear = 1'b1; step(1); fail_clear = 1'b0;
        chk("to_clear", 32'(lock_fail), 0);
        step(278);
        fail_clear = 1'b1; step(1); fail_clear = 1'b0;
        chk("to_set_wins", 32'(lock_fail), 1);

        // Reset in the middle of PLL_RST
        step(26); chk("mid_pll", 32'(sel_onehot), 32'h4);
        rst = 1'b1; step(1);
        chk("abort_onehot", 32'(sel_onehot), 0);
        chk("abort_sel", 32'(sel_idx), 3);
        chk("abort_fail", 32'(lock_fail), 0);
        chk("abort_q", 32'(src_qualified), 0);
        rst = 1'b0;
        step(15); chk("restart_off", 32'(sel_onehot), 0);
        step(1);  chk("restart_on", 32'(sel_onehot), 32'h8);

        // Forced switches until the counter saturates
        mmcm_locked = 1'b1; src_active = 4'b0111;
        step(100);
        for (int k = 0; k < 18; k++) begin
            manual_sel = (k % 2 == 0) ? 2'd1 : 2'd0;
            step(90);
        end
        chk("saturate", 32'(switch_count), 32'hF);

        // Randomised traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) == 0) src_active[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 299) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) manual_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) mmcm_locked = ~mmcm_locked;
            fail_clear = ($urandom_range(0, 149) == 0);
            rst = ($urandom_range(0, 1999) == 0);
            step(1);
        end
        rst = 1'b0; fail_clear = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_source_sel.md
# clk_source_sel

Parametrised clock-source selection controller for N candidate reference clocks feeding one BUFGCTRL tree and one downstream MMCM. It qualifies each source's activity flag, chooses a target per a runtime mode (manual, auto-priority, auto-sticky), and sequences every switch: selects off, then MMCM reset, then wait for lock, with timeout and retry. It runs on the free-running control clock and replaces hard-wired two-input ext/int muxing with an N-way, glitch-safe, lock-supervised switchover.

## Interface
- N_SRC, 4: number of candidate sources (2..16); SEL_W = $clog2(N_SRC) is derived.
- DEFAULT_SRC, N_SRC-1: fallback source index (local oscillator), used when nothing is qualified.
- QUAL_CYCLES, 1024: consecutive active cycles required to qualify a source.
- DEAD_CYCLES, 16: cycles with all selects low before a new select is driven.
- RST_CYCLES, 64: MMCM reset hold length.
- LOCK_TIMEOUT, 65535: cycles allowed in WAIT_LOCK.
- CNT_W, 16: switch_count width.
- clk  in  1  control clock; all ports synchronous to it.
- rst  in  1  reset, synchronous, active-high.
- src_active  in  N_SRC  per-source activity flags, already synchronised to clk.
- mode  in  2  0 manual, 1 auto-priority, 2 auto-sticky, 3 treated as 1.
- manual_sel  in  SEL_W  requested source in manual mode; values >= N_SRC are treated as DEFAULT_SRC.
- mmcm_locked  in  1  downstream MMCM lock, already synchronised.
- fail_clear  in  1  one-cycle pulse clearing lock_fail.
- sel_onehot  out  N_SRC  BUFGCTRL select lines.
- sel_idx  out  SEL_W  index of the current/pending source.
- mmcm_rst  out  1  MMCM reset, active-high.
- locked_out  out  1  selected path valid and locked.
- src_qualified  out  N_SRC  per-source qualification status.
- switch_count  out  CNT_W  saturating count of source changes.
- lock_fail  out  1  sticky lock-timeout flag.

## Operation
- Qualification: per-source counter increments while src_active=1 and clears on src_active=0. src_qualified[i] sets on the cycle after QUAL_CYCLES consecutive 1s and clears on the cycle after the first 0.
- Target: manual → manual_sel if qualified, else lowest-index qualified source. Auto-priority → lowest-index qualified source. Auto-sticky → sel_idx if qualified, else lowest-index qualified source. No source qualified → DEFAULT_SRC.
- FSM states are OFF, PLL_RST, WAIT_LOCK and RUN.
- OFF: sel_onehot=0, mmcm_rst=1, DEAD_CYCLES cycles, then PLL_RST. The target is latched into sel_idx on entry.
- PLL_RST: sel_onehot=onehot(sel_idx), mmcm_rst=1, RST_CYCLES cycles, then WAIT_LOCK.
- WAIT_LOCK: mmcm_rst=0. mmcm_locked=1 → RUN. Timeout → set lock_fail, then OFF to retry with a freshly computed target.
- RUN: locked_out=1. Target ≠ sel_idx → OFF with switch_count+1 (saturating at all-ones). mmcm_locked=0 → OFF, with no count change unless the target also differs.
- Target changes in OFF/PLL_RST/WAIT_LOCK are ignored until RUN or the next retry.
- A fail_clear pulse coinciding with a timeout leaves lock_fail set (set wins).
- Reset values: state OFF, sel_idx=DEFAULT_SRC, sel_onehot=0, mmcm_rst=1, locked_out=0, src_qualified=0, switch_count=0, lock_fail=0. rst mid-sequence aborts immediately to these values.

## Timing
- All outputs are registered.
- A state transition is visible one cycle after its condition.
- From rst release: OFF for DEAD_CYCLES cycles, PLL_RST for RST_CYCLES cycles, then WAIT_LOCK.
- mmcm_locked=1 in WAIT_LOCK at cycle t → locked_out=1 at t+1.
- In RUN, mmcm_locked=0 at t → locked_out=0, sel_onehot=0 and mmcm_rst=1 at t+1.
- Qualification loss at t → src_qualified falls at t+1 → target recomputed → OFF entered at t+2.
- Minimum switchover time = DEAD_CYCLES + RST_CYCLES + lock time.

## Structure
- Package clk_source_pkg holds the state enum (OFF, PLL_RST, WAIT_LOCK, RUN) and the mode enum (MODE_MANUAL, MODE_PRIO, MODE_STICKY).
- Sub-module src_qualifier holds one counter and flag per source, generated N_SRC times.
- Target selection is a combinational function inside clk_source_sel.

## Test plan
- Reset release with all src_active=0, mmcm_locked asserted 100 cycles into WAIT_LOCK → sel_idx=3, sel_onehot=4'b1000 from cycle 16, mmcm_rst low at cycle 80, locked_out=1 one cycle after lock.
- Auto-priority: running on src 3, src_active[1]=1 for 1024 cycles → src_qualified[1]=1 at cycle 1025, OFF entered 1 cycle later, sel_idx=1, switch_count=1.
- Auto-sticky: on src 1, src 0 qualifies → no switch. src 1 drops → switch to src 0 within 2 cycles, switch_count increments.
- Manual: manual_sel=2 with src 2 unqualified → lowest qualified source selected. src 2 qualifies → switch to 2.
- mmcm_locked never asserts → lock_fail=1 after 65535 WAIT_LOCK cycles, retry through OFF. fail_clear clears the flag. Simultaneous fail_clear and timeout → flag stays 1.
- rst asserted mid-PLL_RST → next cycle all outputs at reset values, sequence restarts from OFF. switch_count saturates at 16'hFFFF under repeated forced switches.
